// File: rtl/hand_bbox_pkg.sv
// Shared types and helpers for the hand bounding-box tracker.
// Holds the coordinate/count widths, the frame FSM states and saturating arithmetic.
package hand_bbox_pkg;

    localparam int COORD_W = 12;
    localparam int CNT_W   = 20;

    localparam logic [COORD_W-1:0] COORD_MAX = '1;
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    function automatic logic [COORD_W-1:0] coord_sat_add(
        input logic [COORD_W-1:0] a,
        input logic [COORD_W-1:0] b
    );
        logic [COORD_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[COORD_W] ? COORD_MAX : sum[COORD_W-1:0];
    endfunction

    function automatic logic [COORD_W-1:0] coord_sat_inc(input logic [COORD_W-1:0] a);
        return (a == COORD_MAX) ? a : a + 1'b1;
    endfunction

endpackage

// File: rtl/hand_bbox_tracker_skin_classifier.sv
// Combinational skin test on one RGB pixel using fixed thresholds.
// Differences are taken at 9 bits so a negative R-G or R-B can never wrap into a pass.
module skin_classifier #(
    parameter logic [7:0] R_MIN     = 8'd96,
    parameter logic [7:0] RG_MARGIN = 8'd20,
    parameter logic [7:0] RB_MARGIN = 8'd20
) (
    input  logic [7:0] red_i,
    input  logic [7:0] green_i,
    input  logic [7:0] blue_i,
    output logic       is_skin_o
);

    logic [8:0] rg_diff;
    logic [8:0] rb_diff;
    logic       r_gt_g;
    logic       r_gt_b;
    logic       rg_ok;
    logic       rb_ok;
    logic       r_ok;

    assign rg_diff = {1'b0, red_i} - {1'b0, green_i};
    assign rb_diff = {1'b0, red_i} - {1'b0, blue_i};

    // Bit 8 set means the subtraction borrowed, i.e. the other channel is larger.
    assign r_gt_g = !rg_diff[8] && (rg_diff != 9'd0);
    assign r_gt_b = !rb_diff[8] && (rb_diff != 9'd0);

    assign rg_ok = r_gt_g && (rg_diff >= {1'b0, RG_MARGIN});
    assign rb_ok = r_gt_b && (rb_diff >= {1'b0, RB_MARGIN});
    assign r_ok  = (red_i >= R_MIN);

    assign is_skin_o = r_ok && rg_ok && rb_ok;

endmodule

// File: rtl/hand_bbox_tracker.sv
// Per-frame skin bounding-box tracker feeding the VGA overlay stage.
// Box outputs only change at frame commit, already shifted into display-timing coordinates.
module hand_bbox_tracker
    import hand_bbox_pkg::*;
#(
    parameter logic [7:0]         R_MIN       = 8'd96,
    parameter logic [7:0]         RG_MARGIN   = 8'd20,
    parameter logic [7:0]         RB_MARGIN   = 8'd20,
    parameter int                 RUN_MIN     = 4,
    parameter int                 MIN_PIXELS  = 64,
    parameter int                 MISS_FRAMES = 3,
    parameter logic [COORD_W-1:0] X_OFFSET    = 12'd144,
    parameter logic [COORD_W-1:0] Y_OFFSET    = 12'd35
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic               iFVAL,
    input  logic               iLVAL,
    input  logic               iDVAL,
    input  logic [7:0]         iRed,
    input  logic [7:0]         iGreen,
    input  logic [7:0]         iBlue,
    output logic [COORD_W-1:0] hand_x_min,
    output logic [COORD_W-1:0] hand_x_max,
    output logic [COORD_W-1:0] hand_y_min,
    output logic [COORD_W-1:0] hand_y_max,
    output logic               oBox_valid,
    output logic               oFrame_done,
    output logic [CNT_W-1:0]   oPix_count
);

    localparam int RUN_W  = 8;
    localparam int MISS_W = 8;

    localparam logic [RUN_W-1:0]   RUN_MIN_C  = RUN_W'(RUN_MIN);
    localparam logic [COORD_W-1:0] RUN_BACK_C = COORD_W'(RUN_MIN - 1);
    localparam logic [CNT_W-1:0]   MIN_PIX_C  = CNT_W'(MIN_PIXELS);
    localparam logic [MISS_W-1:0]  MISS_C     = MISS_W'(MISS_FRAMES);

    state_t             state_q, state_d;
    logic               fval_prev_q;
    logic               lval_prev_q;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [CNT_W-1:0]   hits_q, hits_d;
    logic [COORD_W-1:0] acc_xmin_q, acc_xmin_d;
    logic [COORD_W-1:0] acc_xmax_q, acc_xmax_d;
    logic [COORD_W-1:0] acc_ymin_q, acc_ymin_d;
    logic [COORD_W-1:0] acc_ymax_q, acc_ymax_d;
    logic [MISS_W-1:0]  miss_q, miss_d;
    logic [COORD_W-1:0] box_xmin_q, box_xmin_d;
    logic [COORD_W-1:0] box_xmax_q, box_xmax_d;
    logic [COORD_W-1:0] box_ymin_q, box_ymin_d;
    logic [COORD_W-1:0] box_ymax_q, box_ymax_d;
    logic               box_valid_q, box_valid_d;
    logic               frame_done_q, frame_done_d;
    logic [CNT_W-1:0]   pix_count_q, pix_count_d;

    logic               is_skin;
    logic               pix_acc;
    logic               lval_fall;
    logic               fval_rise;
    logic [RUN_W-1:0]   run_inc;
    logic               hit;
    logic [COORD_W-1:0] run_start;
    logic [MISS_W-1:0]  miss_inc;

    skin_classifier #(
        .R_MIN     (R_MIN),
        .RG_MARGIN (RG_MARGIN),
        .RB_MARGIN (RB_MARGIN)
    ) u_skin (
        .red_i     (iRed),
        .green_i   (iGreen),
        .blue_i    (iBlue),
        .is_skin_o (is_skin)
    );

    assign pix_acc   = iFVAL && iLVAL && iDVAL;
    assign lval_fall = lval_prev_q && !iLVAL;
    assign fval_rise = !fval_prev_q && iFVAL;
    assign run_inc   = (run_q == '1) ? run_q : run_q + 1'b1;
    assign hit       = pix_acc && is_skin && (run_inc >= RUN_MIN_C);
    assign run_start = x_q - RUN_BACK_C;
    assign miss_inc  = (miss_q >= MISS_C) ? miss_q : miss_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        run_d        = run_q;
        hits_d       = hits_q;
        acc_xmin_d   = acc_xmin_q;
        acc_xmax_d   = acc_xmax_q;
        acc_ymin_d   = acc_ymin_q;
        acc_ymax_d   = acc_ymax_q;
        miss_d       = miss_q;
        box_xmin_d   = box_xmin_q;
        box_xmax_d   = box_xmax_q;
        box_ymin_d   = box_ymin_q;
        box_ymax_d   = box_ymax_q;
        box_valid_d  = box_valid_q;
        frame_done_d = 1'b0;
        pix_count_d  = pix_count_q;

        case (state_q)
            IDLE: begin
                if (fval_rise) begin
                    state_d    = ACCUM;
                    x_d        = '0;
                    y_d        = '0;
                    run_d      = '0;
                    hits_d     = '0;
                    acc_xmin_d = COORD_MAX;
                    acc_ymin_d = COORD_MAX;
                    acc_xmax_d = '0;
                    acc_ymax_d = '0;
                end
            end

            ACCUM: begin
                if (!iFVAL) begin
                    state_d = COMMIT;
                end else begin
                    if (pix_acc) begin
                        x_d   = coord_sat_inc(x_q);
                        run_d = is_skin ? run_inc : '0;
                    end
                    if (hit) begin
                        // The box starts where the qualifying run began, not at the hit pixel.
                        if (run_start < acc_xmin_q) acc_xmin_d = run_start;
                        if (x_q > acc_xmax_q)       acc_xmax_d = x_q;
                        if (y_q < acc_ymin_q)       acc_ymin_d = y_q;
                        if (y_q > acc_ymax_q)       acc_ymax_d = y_q;
                        hits_d = (hits_q == CNT_MAX) ? hits_q : hits_q + 1'b1;
                    end
                    if (!iLVAL) begin
                        run_d = '0;
                    end
                    if (lval_fall) begin
                        x_d = '0;
                        y_d = coord_sat_inc(y_q);
                    end
                end
            end

            COMMIT: begin
                state_d      = IDLE;
                frame_done_d = 1'b1;
                pix_count_d  = hits_q;
                if (hits_q >= MIN_PIX_C) begin
                    box_xmin_d  = coord_sat_add(acc_xmin_q, X_OFFSET);
                    box_xmax_d  = coord_sat_add(acc_xmax_q, X_OFFSET);
                    box_ymin_d  = coord_sat_add(acc_ymin_q, Y_OFFSET);
                    box_ymax_d  = coord_sat_add(acc_ymax_q, Y_OFFSET);
                    box_valid_d = 1'b1;
                    miss_d      = '0;
                end else begin
                    // Short dropouts keep the last box so the overlay does not flicker.
                    miss_d = miss_inc;
                    if (miss_inc >= MISS_C) begin
                        box_xmin_d  = '0;
                        box_xmax_d  = '0;
                        box_ymin_d  = '0;
                        box_ymax_d  = '0;
                        box_valid_d = 1'b0;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q      <= IDLE;
            // Starting high means a frame already in flight at release is not seen as a new frame.
            fval_prev_q  <= 1'b1;
            lval_prev_q  <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            run_q        <= '0;
            hits_q       <= '0;
            acc_xmin_q   <= '0;
            acc_xmax_q   <= '0;
            acc_ymin_q   <= '0;
            acc_ymax_q   <= '0;
            miss_q       <= '0;
            box_xmin_q   <= '0;
            box_xmax_q   <= '0;
            box_ymin_q   <= '0;
            box_ymax_q   <= '0;
            box_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            pix_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            fval_prev_q  <= iFVAL;
            lval_prev_q  <= iLVAL;
            x_q          <= x_d;
            y_q          <= y_d;
            run_q        <= run_d;
            hits_q       <= hits_d;
            acc_xmin_q   <= acc_xmin_d;
            acc_xmax_q   <= acc_xmax_d;
            acc_ymin_q   <= acc_ymin_d;
            acc_ymax_q   <= acc_ymax_d;
            miss_q       <= miss_d;
            box_xmin_q   <= box_xmin_d;
            box_xmax_q   <= box_xmax_d;
            box_ymin_q   <= box_ymin_d;
            box_ymax_q   <= box_ymax_d;
            box_valid_q  <= box_valid_d;
            frame_done_q <= frame_done_d;
            pix_count_q  <= pix_count_d;
        end
    end

    assign hand_x_min  = box_xmin_q;
    assign hand_x_max  = box_xmax_q;
    assign hand_y_min  = box_ymin_q;
    assign hand_y_max  = box_ymax_q;
    assign oBox_valid  = box_valid_q;
    assign oFrame_done = frame_done_q;
    assign oPix_count  = pix_count_q;

endmodule

// File: tb/tb_hand_bbox_tracker.sv
// Bench for hand_bbox_tracker: streams small frames from an image array and checks every cycle
// against a frame-level model that scans the image for skin runs.
module tb_hand_bbox_tracker;

    localparam int W = 64;
    localparam int H = 48;

    logic        iCLK = 1'b0;
    logic        iRST_N = 1'b0;
    logic        iFVAL = 1'b0;
    logic        iLVAL = 1'b0;
    logic        iDVAL = 1'b0;
    logic [7:0]  iRed = 8'd0;
    logic [7:0]  iGreen = 8'd0;
    logic [7:0]  iBlue = 8'd0;
    logic [11:0] hand_x_min;
    logic [11:0] hand_x_max;
    logic [11:0] hand_y_min;
    logic [11:0] hand_y_max;
    logic        oBox_valid;
    logic        oFrame_done;
    logic [19:0] oPix_count;

    always #5 iCLK = ~iCLK;

    hand_bbox_tracker dut (
        .iCLK        (iCLK),
        .iRST_N      (iRST_N),
        .iFVAL       (iFVAL),
        .iLVAL       (iLVAL),
        .iDVAL       (iDVAL),
        .iRed        (iRed),
        .iGreen      (iGreen),
        .iBlue       (iBlue),
        .hand_x_min  (hand_x_min),
        .hand_x_max  (hand_x_max),
        .hand_y_min  (hand_y_min),
        .hand_y_max  (hand_y_max),
        .oBox_valid  (oBox_valid),
        .oFrame_done (oFrame_done),
        .oPix_count  (oPix_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] img_r [H][W];
    logic [7:0] img_g [H][W];
    logic [7:0] img_b [H][W];

    // Expected DUT outputs, maintained by the model.
    logic [11:0] exp_xmin = 12'd0;
    logic [11:0] exp_xmax = 12'd0;
    logic [11:0] exp_ymin = 12'd0;
    logic [11:0] exp_ymax = 12'd0;
    logic        exp_valid = 1'b0;
    logic        exp_done = 1'b0;
    logic [19:0] exp_pix = 20'd0;
    int          miss_m = 0;
    bit          chk_en = 1'b0;

    function automatic bit skin_m(input int r, input int g, input int b);
        return (r >= 96) && (r - g >= 20) && (r - b >= 20);
    endfunction

    function automatic logic [11:0] disp(input int v, input int off);
        int s;
        s = v + off;
        if (s > 4095) s = 4095;
        return 12'(s);
    endfunction

    task automatic check(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    always @(negedge iCLK) begin
        if (chk_en) begin
            n_tests++;
            if (hand_x_min !== exp_xmin || hand_x_max !== exp_xmax ||
                hand_y_min !== exp_ymin || hand_y_max !== exp_ymax ||
                oBox_valid !== exp_valid || oFrame_done !== exp_done ||
                oPix_count !== exp_pix) begin
                n_fail++;
                $display("FAIL cycle_cmp t=%0t: got box=(%0d,%0d,%0d,%0d) v=%0b done=%0b pix=%0d, expected box=(%0d,%0d,%0d,%0d) v=%0b done=%0b pix=%0d",
                         $time, hand_x_min, hand_x_max, hand_y_min, hand_y_max, oBox_valid,
                         oFrame_done, oPix_count, exp_xmin, exp_xmax, exp_ymin, exp_ymax,
                         exp_valid, exp_done, exp_pix);
            end
        end
    end

    task automatic model_reset();
        exp_xmin = 0; exp_xmax = 0; exp_ymin = 0; exp_ymax = 0;
        exp_valid = 0; exp_done = 0; exp_pix = 0; miss_m = 0;
    endtask

    // Scan the image as rows of pixels: a hit is any skin pixel that ends a run of >= 4.
    task automatic model_commit();
        int hits, xmin, xmax, ymin, ymax, run;
        hits = 0; xmin = 4095; xmax = 0; ymin = 4095; ymax = 0;
        for (int y = 0; y < H; y++) begin
            run = 0;
            for (int x = 0; x < W; x++) begin
                if (skin_m(img_r[y][x], img_g[y][x], img_b[y][x])) run++;
                else run = 0;
                if (run >= 4) begin
                    hits++;
                    if (x - 3 < xmin) xmin = x - 3;
                    if (x > xmax) xmax = x;
                    if (y < ymin) ymin = y;
                    if (y > ymax) ymax = y;
                end
            end
        end
        exp_pix = 20'(hits);
        if (hits >= 64) begin
            exp_xmin = disp(xmin, 144); exp_xmax = disp(xmax, 144);
            exp_ymin = disp(ymin, 35);  exp_ymax = disp(ymax, 35);
            exp_valid = 1; miss_m = 0;
        end else begin
            if (miss_m < 3) miss_m++;
            if (miss_m >= 3) begin
                exp_xmin = 0; exp_xmax = 0; exp_ymin = 0; exp_ymax = 0; exp_valid = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic clear_img();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                img_r[y][x] = 0; img_g[y][x] = 0; img_b[y][x] = 0;
            end
    endtask

    task automatic fill_rect(input int x0, input int x1, input int y0, input int y1,
                             input int r, input int g, input int b);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++) begin
                img_r[y][x] = 8'(r); img_g[y][x] = 8'(g); img_b[y][x] = 8'(b);
            end
    endtask

    task automatic fill_random();
        int n, x0, y0, w, h, r;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                img_r[y][x] = 8'($urandom_range(0, 255));
                img_g[y][x] = 8'($urandom_range(0, 255));
                img_b[y][x] = 8'($urandom_range(0, 255));
            end
        n = $urandom_range(0, 2);
        for (int k = 0; k < n; k++) begin
            w = $urandom_range(3, 16); h = $urandom_range(2, 10);
            x0 = $urandom_range(0, W - w); y0 = $urandom_range(0, H - h);
            r = $urandom_range(116, 255);
            fill_rect(x0, x0 + w - 1, y0, y0 + h - 1, r,
                      $urandom_range(0, r - 20), $urandom_range(0, r - 20));
        end
    endtask

    // Stream the image; rst_line >= 0 pulses reset partway through that line, aborting the frame.
    task automatic send_frame(input bit gaps, input int rst_line);
        bit aborted;
        aborted = 0;
        iFVAL = 1;
        for (int i = 0; i < 3; i++) tick();
        for (int y = 0; y < H; y++) begin
            iLVAL = 1;
            for (int x = 0; x < W; x++) begin
                if (y == rst_line && x == W / 2) begin
                    iRST_N = 0;
                    model_reset();
                    aborted = 1;
                    tick(); tick();
                    iRST_N = 1;
                end
                if (gaps && $urandom_range(0, 3) == 0) begin
                    iDVAL = 0;
                    iRed = 8'($urandom); iGreen = 8'($urandom); iBlue = 8'($urandom);
                    tick();
                end
                iDVAL = 1;
                iRed = img_r[y][x]; iGreen = img_g[y][x]; iBlue = img_b[y][x];
                tick();
            end
            iLVAL = 0;
            iDVAL = gaps ? 1'($urandom) : 1'b0;
            iRed = 8'd200; iGreen = 8'd10; iBlue = 8'd10;
            if (y == H - 1) begin
                iFVAL = 0;
                iDVAL = 0;
            end else begin
                for (int i = 0; i < 3; i++) tick();
            end
        end
        tick();  // FSM samples iFVAL low
        tick();  // commit edge
        if (!aborted) begin
            model_commit();
            exp_done = 1;
        end
        tick();
        exp_done = 0;
        for (int i = 0; i < 4; i++) tick();
    endtask

    initial begin
        iRST_N = 0;
        model_reset();
        tick(); tick();
        chk_en = 1;
        tick();
        check("reset_valid", oBox_valid, 0);
        check("reset_xmax", hand_x_max, 0);
        iRST_N = 1;
        for (int i = 0; i < 3; i++) tick();

        // Test 1: single skin rectangle.
        clear_img();
        fill_rect(10, 29, 5, 14, 200, 100, 90);
        send_frame(0, -1);
        $display("[TB] frame rect: box=(%0d,%0d,%0d,%0d) pix=%0d", hand_x_min, hand_x_max, hand_y_min, hand_y_max, oPix_count);
        check("t1_model_xmin", exp_xmin, 154);
        check("t1_xmin", hand_x_min, 154);
        check("t1_xmax", hand_x_max, 173);
        check("t1_ymin", hand_y_min, 40);
        check("t1_ymax", hand_y_max, 49);
        check("t1_pix", oPix_count, 170);
        check("t1_valid", oBox_valid, 1);

        // Test 2: only 3-pixel runs, never qualifying.
        clear_img();
        for (int y = 5; y < 25; y++)
            for (int x = 0; x < W; x++)
                if (x % 4 != 3) fill_rect(x, x, y, y, 200, 100, 90);
        send_frame(0, -1);
        $display("[TB] frame short runs: pix=%0d valid=%0b", oPix_count, oBox_valid);
        check("t2_pix", oPix_count, 0);
        check("t2_xmin_held", hand_x_min, 154);
        check("t2_valid_held", oBox_valid, 1);

        // Test 5: block on the right/bottom edge; also reloads a valid box.
        clear_img();
        fill_rect(50, 63, 40, 47, 200, 100, 90);
        send_frame(0, -1);
        $display("[TB] frame edge: box=(%0d,%0d,%0d,%0d) pix=%0d", hand_x_min, hand_x_max, hand_y_min, hand_y_max, oPix_count);
        check("t5_xmin", hand_x_min, 194);
        check("t5_xmax", hand_x_max, 207);
        check("t5_ymin", hand_y_min, 75);
        check("t5_ymax", hand_y_max, 82);
        check("t5_pix", oPix_count, 88);

        // Test 3: three black frames drop the box on the third.
        clear_img();
        for (int f = 1; f <= 3; f++) begin
            send_frame(0, -1);
            $display("[TB] black frame %0d: valid=%0b xmax=%0d", f, oBox_valid, hand_x_max);
            check("t3_valid", oBox_valid, (f < 3) ? 1 : 0);
            check("t3_xmax", hand_x_max, (f < 3) ? 207 : 0);
        end

        // Test 4: reset mid-frame, then a normal frame.
        clear_img();
        fill_rect(10, 29, 5, 14, 200, 100, 90);
        send_frame(0, 20);
        $display("[TB] aborted frame: valid=%0b pix=%0d", oBox_valid, oPix_count);
        check("t4_abort_valid", oBox_valid, 0);
        send_frame(0, -1);
        $display("[TB] frame after reset: box=(%0d,%0d,%0d,%0d) pix=%0d", hand_x_min, hand_x_max, hand_y_min, hand_y_max, oPix_count);
        check("t4_xmin", hand_x_min, 154);
        check("t4_pix", oPix_count, 170);

        // Test 6: colour thresholds at the boundary, 10-pixel runs.
        clear_img();
        fill_rect(20, 29, 10, 19, 96, 76, 76);
        fill_rect(5, 14, 25, 25, 95, 76, 76);
        fill_rect(5, 14, 30, 30, 96, 77, 76);
        fill_rect(5, 14, 31, 31, 96, 76, 77);
        send_frame(0, -1);
        $display("[TB] frame boundary colours: box=(%0d,%0d,%0d,%0d) pix=%0d", hand_x_min, hand_x_max, hand_y_min, hand_y_max, oPix_count);
        check("t6_xmin", hand_x_min, 164);
        check("t6_xmax", hand_x_max, 173);
        check("t6_ymin", hand_y_min, 45);
        check("t6_ymax", hand_y_max, 54);
        check("t6_pix", oPix_count, 70);

        // Randomized frames with pixel-valid gaps and blanking noise.
        for (int f = 0; f < 4; f++) begin
            fill_random();
            send_frame(1, -1);
            $display("[TB] random frame %0d: box=(%0d,%0d,%0d,%0d) v=%0b pix=%0d", f, hand_x_min, hand_x_max, hand_y_min, hand_y_max, oBox_valid, oPix_count);
        end

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
